// File: rtl/counter_pkg.sv
// Shared constants and helpers for the modulo counter and its prescaler.
package counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Bits needed to hold 0..v-1, never less than 1 so a divider always has a real width.
    function automatic int clog2_min1(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++)
            if ((64'd1 << r) < 64'(v)) r = r + 1;
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/cnt_prescaler.sv
// Enable prescaler: asserts tick on every PRESCALE-th enabled cycle.
// clr (load) and reset discard any partial count.
module cnt_prescaler
    import counter_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);

    if (PRESCALE < 1) begin : g_bad_p
        $error("cnt_prescaler: PRESCALE must be >= 1");
    end

    if (PRESCALE == 1) begin : g_direct
        logic unused_p1;
        assign unused_p1 = ^{clk, reset, clr};
        assign tick      = en;
    end else begin : g_div
        localparam int            DW      = clog2_min1(PRESCALE);
        localparam logic [DW-1:0] DIV_MAX = DW'(PRESCALE - 1);

        logic [DW-1:0] div;

        always_ff @(posedge clk) begin
            if (reset || clr)
                div <= '0;
            else if (en)
                div <= (div == DIV_MAX) ? '0 : div + 1'b1;
        end

        assign tick = en && (div == DIV_MAX);
    end

endmodule

// File: rtl/mod_updown_counter.sv
// Parametrised up/down modulo counter with load, prescaler and terminal-count pulse.
// Define MOD_COUNTER_SATURATE_EN to stop at the limits instead of wrapping.
module mod_updown_counter
    import counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 2 ** WIDTH,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             zero
);

    if (WIDTH < 2) begin : g_bad_w
        $error("mod_updown_counter: WIDTH must be >= 2");
    end
    if (MODULUS < 2 || MODULUS > 2 ** WIDTH) begin : g_bad_m
        $error("mod_updown_counter: MODULUS must be in 2..2**WIDTH");
    end

    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 1);

    logic             tick;
    logic [WIDTH-1:0] q_nxt;
    logic [WIDTH-1:0] q_load;
    logic             hit;

    cnt_prescaler #(.PRESCALE(PRESCALE)) u_pre (
        .clk   (clk),
        .reset (reset),
        .clr   (load),
        .en    (en),
        .tick  (tick)
    );

    assign q_load = (load_val > MAXV) ? MAXV : load_val;

    // hit marks the step that earns a tc pulse: a wrap, or reaching a limit when saturating.
    always_comb begin
        q_nxt = q;
        hit   = 1'b0;
        if (up_dn == DIR_UP) begin
            if (q == MAXV) begin
`ifdef MOD_COUNTER_SATURATE_EN
                q_nxt = q;
`else
                q_nxt = '0;
                hit   = 1'b1;
`endif
            end else begin
                q_nxt = q + 1'b1;
`ifdef MOD_COUNTER_SATURATE_EN
                hit   = (q_nxt == MAXV);
`endif
            end
        end else begin
            if (q == '0) begin
`ifdef MOD_COUNTER_SATURATE_EN
                q_nxt = q;
`else
                q_nxt = MAXV;
                hit   = 1'b1;
`endif
            end else begin
                q_nxt = q - 1'b1;
`ifdef MOD_COUNTER_SATURATE_EN
                hit   = (q_nxt == '0);
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q  <= '0;
            tc <= 1'b0;
        end else if (load) begin
            q  <= q_load;
            tc <= 1'b0;
        end else if (tick) begin
            q  <= q_nxt;
            tc <= hit;
        end else begin
            tc <= 1'b0;
        end
    end

    assign zero = (q == '0);

endmodule

// File: tb/tb_mod_updown_counter.sv
// Scoreboarded random/directed bench: two counters (mod 16 / P=1 and mod 10 / P=3) share stimulus.
module tb_mod_updown_counter;

    logic       clk = 1'b0;
    logic       reset = 1'b1, en = 1'b0, up_dn = 1'b1, load = 1'b0;
    logic [3:0] load_val = '0;
    logic [3:0] qa, qb;
    logic       tca, tcb, zeroa, zerob;

    always #5 clk = ~clk;

    mod_updown_counter #(.WIDTH(4), .MODULUS(16), .PRESCALE(1)) dut_a (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .q(qa), .tc(tca), .zero(zeroa)
    );

    mod_updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(3)) dut_b (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .q(qb), .tc(tcb), .zero(zerob)
    );

    typedef struct {
        int qa; int tca;
        int qb; int tcb;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   done   = 1'b0;

    // Reference model state: count, enabled cycles since last step, tc.
    int a_q = 0, a_cnt = 0, a_tc = 0;
    int b_q = 0, b_cnt = 0, b_tc = 0;

    task automatic model_step(input int m, input int p, input bit r, input bit e,
                              input bit u, input bit l, input int lv,
                              inout int mq, inout int mcnt, inout int mtc);
        if (r) begin
            mq = 0; mcnt = 0; mtc = 0;
        end else if (l) begin
            mq = (lv < m) ? lv : m - 1; mcnt = 0; mtc = 0;
        end else if (e) begin
            mcnt = mcnt + 1;
            mtc  = 0;
            if (mcnt == p) begin
                mcnt = 0;
`ifdef MOD_COUNTER_SATURATE_EN
                if (u && mq < m - 1) begin
                    mq = mq + 1; mtc = (mq == m - 1);
                end else if (!u && mq > 0) begin
                    mq = mq - 1; mtc = (mq == 0);
                end
`else
                if (u) begin
                    mq = (mq + 1) % m; mtc = (mq == 0);
                end else begin
                    mq = (mq + m - 1) % m; mtc = (mq == m - 1);
                end
`endif
            end
        end else begin
            mtc = 0;
        end
    endtask

    task automatic drive(input bit r, input bit e, input bit u, input bit l, input int lv);
        exp_t x;
        @(negedge clk);
        reset = r; en = e; up_dn = u; load = l; load_val = 4'(lv);
        model_step(16, 1, r, e, u, l, lv, a_q, a_cnt, a_tc);
        model_step(10, 3, r, e, u, l, lv, b_q, b_cnt, b_tc);
        x.qa = a_q; x.tca = a_tc; x.qb = b_q; x.tcb = b_tc;
        exp_q.push_back(x);
    endtask

    task automatic chk(input string name, input logic [3:0] act, input int expv);
        checks = checks + 1;
        if (act !== 4'(expv)) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    // Monitor: the counter presents a result every cycle; compare just after each edge.
    initial begin
        exp_t x;
        while (!done) begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                chk("qa",    qa,    x.qa);
                chk("tca",   {3'b0, tca},   x.tca);
                chk("zeroa", {3'b0, zeroa}, (x.qa == 0) ? 1 : 0);
                chk("qb",    qb,    x.qb);
                chk("tcb",   {3'b0, tcb},   x.tcb);
                chk("zerob", {3'b0, zerob}, (x.qb == 0) ? 1 : 0);
            end
        end
    end

    initial begin
        // reset dominates en/load
        repeat (2) drive(1, 1, 1, 1, 5);
        // count up through the wrap of both moduli
        repeat (20) drive(0, 1, 1, 0, 0);
        // down from 0 wraps to MODULUS-1
        drive(0, 0, 0, 1, 0);
        repeat (8) drive(0, 1, 0, 0, 0);
        // clamp load on the mod-10 counter
        drive(0, 0, 1, 1, 12);
        repeat (2) drive(0, 0, 1, 0, 0);
        // prescaler holds through en gaps
        drive(0, 0, 1, 1, 0);
        drive(0, 1, 1, 0, 0);
        repeat (2) drive(0, 0, 1, 0, 0);
        repeat (4) drive(0, 1, 1, 0, 0);
        // load beats a due tick
        drive(0, 0, 1, 1, 3);
        repeat (2) drive(0, 1, 1, 0, 0);
        drive(0, 1, 1, 1, 7);
        repeat (3) drive(0, 1, 1, 0, 0);
        // run into the upper limit, reverse, then reset mid-count
        drive(0, 0, 1, 1, 14);
        repeat (12) drive(0, 1, 1, 0, 0);
        repeat (4) drive(0, 1, 0, 0, 0);
        drive(1, 1, 0, 0, 0);
        drive(0, 1, 1, 0, 0);
        // random traffic
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 99) < 2),
                  ($urandom_range(0, 99) < 75),
                  1'($urandom_range(0, 1)),
                  ($urandom_range(0, 99) < 8),
                  int'($urandom_range(0, 15)));
        end
        drive(0, 0, 1, 0, 0);
        @(posedge clk);
        #3;
        done = 1'b1;
        checks = checks + 1;
        if (exp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL drain: %0d results left unchecked, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
